// File: rtl/cdb_arbiter.sv
// cdb_arbiter: three per-source result FIFOs with round-robin broadcast onto a registered CDB
module cdb_arbiter #(
    parameter int DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        flush,
    input  logic        alu1_result_flag,
    input  logic [3:0]  alu1_rob_dest,
    input  logic [31:0] alu1_value,
    input  logic        alu2_result_flag,
    input  logic [3:0]  alu2_rob_dest,
    input  logic [31:0] alu2_value,
    input  logic        lsb_result_flag,
    input  logic [3:0]  lsb_rob_dest,
    input  logic [31:0] lsb_value,
    output logic        alu1_busy,
    output logic        alu2_busy,
    output logic        lsb_busy,
    output logic        cdb_flag,
    output logic [3:0]  cdb_rename,
    output logic [31:0] cdb_value,
    output logic [1:0]  cdb_src,
    output logic        overflow
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [2:0]    flag;
    logic [3:0]    dest [3];
    logic [31:0]   val [3];
    logic [35:0]   mem [3][DEPTH];
    logic [PW-1:0] rp [3];
    logic [PW-1:0] wp [3];
    logic [CW-1:0] cnt [3];
    logic [2:0]    ne, full, enq, deq;
    logic [1:0]    last_grant, s0, s1, s2, gsrc;
    logic          gvld;
    logic [35:0]   head;

    assign flag = {lsb_result_flag, alu2_result_flag, alu1_result_flag};
    assign dest[0] = alu1_rob_dest;
    assign dest[1] = alu2_rob_dest;
    assign dest[2] = lsb_rob_dest;
    assign val[0] = alu1_value;
    assign val[1] = alu2_value;
    assign val[2] = lsb_value;
    assign alu1_busy = !rst && full[0];
    assign alu2_busy = !rst && full[1];
    assign lsb_busy = !rst && full[2];

    // Round-robin pick over queues that were non-empty before this edge
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            ne[i] = cnt[i] != '0;
            full[i] = cnt[i] == CW'(DEPTH);
        end
        s0 = (last_grant == 2'd2) ? 2'd0 : last_grant + 2'd1;
        s1 = (s0 == 2'd2) ? 2'd0 : s0 + 2'd1;
        s2 = (s1 == 2'd2) ? 2'd0 : s1 + 2'd1;
        gvld = |ne;
        gsrc = ne[s0] ? s0 : ne[s1] ? s1 : s2;
        head = mem[gsrc][rp[gsrc]];
        for (int i = 0; i < 3; i++) begin
            enq[i] = flag[i] && !full[i] && rdy && !flush;
            deq[i] = gvld && gsrc == 2'(i) && rdy && !flush;
        end
    end

    // FIFO storage writes; accepted results land at the write pointer
    always_ff @(posedge clk) begin
        for (int i = 0; i < 3; i++)
            if (!rst && enq[i]) mem[i][wp[i]] <= {dest[i], val[i]};
    end

    // Pointers, counts, broadcast registers, grant history and sticky overflow
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 3; i++) begin
                rp[i] <= '0;
                wp[i] <= '0;
                cnt[i] <= '0;
            end
            cdb_flag <= 1'b0;
            cdb_rename <= '0;
            cdb_value <= '0;
            cdb_src <= '0;
            overflow <= 1'b0;
            last_grant <= 2'd2;
        end else if (rdy) begin
            if (flush) begin
                for (int i = 0; i < 3; i++) begin
                    rp[i] <= '0;
                    wp[i] <= '0;
                    cnt[i] <= '0;
                end
                cdb_flag <= 1'b0;
            end else begin
                for (int i = 0; i < 3; i++) begin
                    wp[i] <= wp[i] + PW'(enq[i]);
                    rp[i] <= rp[i] + PW'(deq[i]);
                    cnt[i] <= cnt[i] + CW'(enq[i]) - CW'(deq[i]);
                end
                if (|(flag & full)) overflow <= 1'b1;
                cdb_flag <= gvld;
                if (gvld) begin
                    cdb_rename <= head[35:32];
                    cdb_value <= head[31:0];
                    cdb_src <= gsrc;
                    last_grant <= gsrc;
                end
            end
        end
    end
endmodule
